lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller sitting between the execute stage and the byte-enabled data memory. It accepts one load or store request at a time and drives the memory's word address, write data and 4-bit byte-write enables. Misaligned accesses are split into two word accesses. Load data is returned sign- or zero-extended with a single-cycle response pulse.

## Interface
- No parameters. Data memory is 32-bit, byte-addressed, word-indexed, with combinational read.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; a request is accepted when `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign encoding.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `mem_addr` out 32: word-aligned address to memory.
- `mem_wdata` out 32: lane-positioned write data.
- `mem_we` out 4: byte write enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_rdata` in 32: combinational read data for `mem_addr`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: illegal funct3; valid with `resp_valid`.

## Operation
- Size by funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- On accept, the controller registers the request fields, plus:
  - off = addr[1:0]
  - size = 1, 2 or 4 bytes
  - cross = (off + size > 4)
- States:
  - IDLE: `req_ready=1`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. Accept goes to ERR if illegal, else FIRST.
  - FIRST: `mem_addr = addr & ~3`, `mem_we = bytemask[3:0]` (stores only). On loads, `mem_rdata` is captured into lo. Next state is SECOND if cross, else DONE.
  - SECOND: `mem_addr = (addr & ~3) + 4`, computed mod 2^32. `mem_we = bytemask[7:4]` (stores only). On loads, `mem_rdata` is captured into hi. Next state is DONE.
  - DONE: `resp_valid=1`, `resp_rdata` = extended result. Next state is IDLE.
  - ERR: `resp_valid=1`, `resp_err=1`, no memory activity. Next state is IDLE.
- Byte mask and write data:
  - bytemask (8 bits) = ((1<<size)-1) << off.
  - Store data is shifted as the 64-bit value `{32'b0, wdata} << (8*off)`.
  - The low word goes to `mem_wdata` in FIRST; the high word in SECOND.
- Load result:
  - Take `{hi, lo} >> (8*off)`, truncate to size.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - If cross is 0, hi is unused.
- Memory outputs are combinational from state and registers. `mem_we` is 0 outside FIRST/SECOND.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. Capture registers clear to 0.
- Latency from the accept edge to `resp_valid`:
  - aligned: 2 cycles;
  - crossing: 3 cycles;
  - illegal: 1 cycle.
- Store bytes commit at the rising edge ending FIRST or SECOND.
- `req_ready` is 0 in every state except IDLE. Requests presented while busy are ignored and not queued.
- The next request can be accepted in the cycle after DONE/ERR. There is no back-to-back accept in the DONE cycle.
- Address 0xFFFFFFFE, LW: the second word is 0x00000000 (wraps).
- Reset asserted mid-operation:
  - `mem_we` drops immediately and no further bytes are written;
  - bytes already written in FIRST remain;
  - no `resp_valid` is issued.

## Structure
- `lsu_pkg` holds:
  - the state enum (IDLE, FIRST, SECOND, DONE, ERR);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a size-decode function.
- Sub-module `lsu_align`: purely combinational lane logic.
  - Store side: bytemask and shifted write data.
  - Load side: right-shift and extend.
- `lsu_ctrl` holds the FSM and the capture registers.

## Test plan
- SW 0x100 data 0xDEADBEEF → FIRST drives `mem_addr` 0x100, `mem_we` 1111, `mem_wdata` 0xDEADBEEF. Then LW 0x100 → `resp_rdata` 0xDEADBEEF, 2 cycles after accept.
- SB 0x103 data 0x000000A5 → `mem_we` 1000, `mem_wdata` 0xA5000000. Then LB 0x103 → 0xFFFFFFA5, and LBU 0x103 → 0x000000A5.
- SW 0x102 data 0x11223344:
  - FIRST: addr 0x100, `mem_we` 1100, `mem_wdata` 0x33440000.
  - SECOND: addr 0x104, `mem_we` 0011, `mem_wdata` 0x00001122.
  - Then LW 0x102 → 0x11223344, 3 cycles after accept.
- SH 0x007 data 0x8001:
  - FIRST: addr 0x004, `mem_we` 1000, `mem_wdata` 0x01000000.
  - SECOND: addr 0x008, `mem_we` 0001, `mem_wdata` 0x00000080.
  - Then LH 0x007 → 0xFFFF8001, and LHU 0x007 → 0x00008001.
- Load funct3 011, or store funct3 100 → `mem_we` stays 0, `resp_valid` and `resp_err` are 1 for one cycle, 1 cycle after accept, `resp_rdata` 0.
- Reset pulse during SECOND of SW 0x102 data 0x11223344 → `mem_we` 0 immediately. Word 0x104 is unchanged, bytes 0x102–0x103 hold 0x44 and 0x33, no `resp_valid`, and `req_ready=1` while reset is held.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store controller.
//   - lsu_state_t : controller FSM states
//   - F3_*        : RV32I funct3 width/sign encodings
//   - size_decode : access size in bytes (1, 2, 4) or 0 for an illegal code
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    SECOND = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads, so a store with BU/HU is illegal.
  function automatic logic [2:0] size_decode(input logic store, input logic [2:0] funct3);
    logic [2:0] size;
    size = 3'd0;
    case (funct3)
      F3_B:    size = 3'd1;
      F3_H:    size = 3'd2;
      F3_W:    size = 3'd4;
      F3_BU:   size = store ? 3'd0 : 3'd1;
      F3_HU:   size = store ? 3'd0 : 3'd2;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store controller.
//   off, size      : byte offset within the first word and access size in bytes
//   load_unsigned  : 1 = zero-extend loads, 0 = sign-extend
//   wdata          : right-justified store data
//   lo, hi         : first and second memory words read for a load
//   bytemask       : 8-bit lane mask spanning both words (low nibble = first word)
//   wdata_lo/hi    : store data positioned for the first/second word
//   load_data      : extracted and extended load result
module lsu_align (
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  bytemask,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [3:0]  first_lane;
  logic [3:0]  end_lane;
  logic [63:0] wdata_shifted;
  logic [63:0] rdata_shifted;
  logic        sign_bit;

  assign first_lane = {2'b00, off};
  assign end_lane   = first_lane + {1'b0, size};

  // Lane gi is written when it falls inside [off, off + size).
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign bytemask[gi] = (4'(gi) >= first_lane) && (4'(gi) < end_lane);
    end
  endgenerate

  // Full store word is shifted; unused lanes are masked off by bytemask.
  assign wdata_shifted = {32'b0, wdata} << {off, 3'b000};
  assign wdata_lo      = wdata_shifted[31:0];
  assign wdata_hi      = wdata_shifted[63:32];

  assign rdata_shifted = {hi, lo} >> {off, 3'b000};

  always_comb begin
    load_data = rdata_shifted[31:0];
    sign_bit  = 1'b0;
    case (size)
      3'd1: begin
        sign_bit  = ~load_unsigned & rdata_shifted[7];
        load_data = {{24{sign_bit}}, rdata_shifted[7:0]};
      end
      3'd2: begin
        sign_bit  = ~load_unsigned & rdata_shifted[15];
        load_data = {{16{sign_bit}}, rdata_shifted[15:0]};
      end
      default: load_data = rdata_shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store controller in front of a byte-enabled,
// combinational-read data memory. Misaligned accesses are split into two
// word accesses.
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only when idle)
//   req_store, req_funct3        : store/load select and RV32I width code
//   req_addr, req_wdata          : byte address and right-justified store data
//   mem_addr, mem_wdata, mem_we  : word address, lane-positioned data, byte enables
//   mem_rdata                    : read data for mem_addr
//   resp_valid, resp_rdata, resp_err : one-cycle completion with load result / error
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  lsu_state_t  state_reg, state_next;
  logic        store_reg;
  logic        unsigned_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  size_reg;
  logic        cross_reg;
  logic [31:0] lo_reg;
  logic [31:0] hi_reg;

  logic        accept;
  logic [2:0]  req_size;
  logic        req_cross;
  logic [31:0] word_addr;
  logic [7:0]  bytemask;
  logic [31:0] wdata_lo;
  logic [31:0] wdata_hi;
  logic [31:0] load_data;

  assign accept    = req_valid && (state_reg == IDLE);
  assign req_size  = size_decode(req_store, req_funct3);
  assign req_cross = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
  assign word_addr = {addr_reg[31:2], 2'b00};

  // Stale hi from an earlier crossing access must not leak into this result.
  lsu_align u_align (
    .off           (addr_reg[1:0]),
    .size          (size_reg),
    .load_unsigned (unsigned_reg),
    .wdata         (wdata_reg),
    .lo            (lo_reg),
    .hi            (cross_reg ? hi_reg : 32'h0),
    .bytemask      (bytemask),
    .wdata_lo      (wdata_lo),
    .wdata_hi      (wdata_hi),
    .load_data     (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      store_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      size_reg     <= 3'd0;
      cross_reg    <= 1'b0;
      lo_reg       <= 32'h0;
      hi_reg       <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        store_reg    <= req_store;
        unsigned_reg <= req_funct3[2];
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        size_reg     <= req_size;
        cross_reg    <= req_cross;
      end
      if (state_reg == FIRST && !store_reg) begin
        lo_reg <= mem_rdata;
      end
      if (state_reg == SECOND && !store_reg) begin
        hi_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_we     = 4'b0000;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          state_next = (req_size == 3'd0) ? ERR : FIRST;
        end
      end
      FIRST: begin
        mem_addr = word_addr;
        if (store_reg) begin
          mem_we    = bytemask[3:0];
          mem_wdata = wdata_lo;
        end
        state_next = cross_reg ? SECOND : DONE;
      end
      SECOND: begin
        // Wraps past 0xFFFFFFFC to word 0.
        mem_addr = word_addr + 32'd4;
        if (store_reg) begin
          mem_we    = bytemask[7:4];
          mem_wdata = wdata_hi;
        end
        state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = store_reg ? 32'h0 : load_data;
        state_next = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed, table-driven bench for lsu_ctrl with a byte-addressed
// memory model (1 KiB, address bits [9:0]) attached to the memory port.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Memory model
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma        = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem[ma + 10'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;     // cycles from accept edge to resp_valid
    logic [31:0] a1;      // FIRST: mem_addr, mem_we, mem_wdata
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic [31:0] a2;      // SECOND (only when lat == 3)
    logic [3:0]  we2;
    logic [31:0] wd2;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] wd1,
                              input logic [31:0] a2, input logic [3:0] we2, input logic [31:0] wd2,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.a1 = a1; v.we1 = we1; v.wd1 = wd1; v.a2 = a2; v.we2 = we2; v.wd2 = wd2;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic do_req(input int idx, input vec_t v);
    int  k;
    bit  done;
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    k = 1;
    done = 1'b0;
    while (!done && k <= 8) begin
      if (k == 1) begin
        chk("ready_busy", 32'(req_ready), 32'd0);
        if (v.lat == 1) begin
          chk("err_no_we", 32'(mem_we), 32'd0);
        end else begin
          chk("first_addr", mem_addr, v.a1);
          chk("first_we", 32'(mem_we), 32'(v.we1));
          chk("first_wdata", mem_wdata, v.wd1);
        end
      end
      if (k == 2 && v.lat == 3) begin
        chk("second_addr", mem_addr, v.a2);
        chk("second_we", 32'(mem_we), 32'(v.we2));
        chk("second_wdata", mem_wdata, v.wd2);
      end
      if (resp_valid) begin
        chk("latency", 32'(k), 32'(v.lat));
        chk("resp_rdata", resp_rdata, v.rdata);
        chk("resp_err", 32'(resp_err), 32'(v.err));
        chk("resp_we_idle", 32'(mem_we), 32'd0);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: vector %0d got no resp_valid within 8 cycles", idx);
    end
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    $display("vec %0d: %s f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             idx, v.store ? "ST" : "LD", v.f3, v.addr, v.wdata, resp_rdata_seen(done), v.err, k);
  endtask

  // Value for the log line only; the checked value is compared inside do_req.
  function automatic logic [31:0] resp_rdata_seen(input bit done);
    return done ? 32'h0 : 32'hFFFFFFFF;
  endfunction

  vec_t vecs[24];

  initial begin
    //                 st    f3      addr          wdata         lat a1            we1    wd1           a2           we2    wd2           rdata         err
    vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,       4'h0, 32'h0,       32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mk(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0000_0100, 4'h8, 32'hA500_0000, 32'h0,       4'h0, 32'h0,       32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'hFFFF_FFA5, 1'b0);
    vecs[4]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0000_00A5, 1'b0);
    vecs[5]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'hA5AD_BEEF, 1'b0);
    vecs[6]  = mk(1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344, 3, 32'h0000_0100, 4'hC, 32'h3344_0000, 32'h0000_0104, 4'h3, 32'h0000_1122, 32'h0,     1'b0);
    vecs[7]  = mk(1'b0, 3'b010, 32'h0000_0102, 32'h0,         3, 32'h0000_0100, 4'h0, 32'h0,        32'h0000_0104, 4'h0, 32'h0,       32'h1122_3344, 1'b0);
    vecs[8]  = mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0000_3344, 1'b0);
    vecs[9]  = mk(1'b0, 3'b000, 32'h0000_0104, 32'h0,         2, 32'h0000_0104, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0000_0022, 1'b0);
    vecs[10] = mk(1'b1, 3'b001, 32'h0000_0007, 32'h0000_8001, 3, 32'h0000_0004, 4'h8, 32'h0100_0000, 32'h0000_0008, 4'h1, 32'h0000_0080, 32'h0,     1'b0);
    vecs[11] = mk(1'b0, 3'b001, 32'h0000_0007, 32'h0,         3, 32'h0000_0004, 4'h0, 32'h0,        32'h0000_0008, 4'h0, 32'h0,       32'hFFFF_8001, 1'b0);
    vecs[12] = mk(1'b0, 3'b101, 32'h0000_0007, 32'h0,         3, 32'h0000_0004, 4'h0, 32'h0,        32'h0000_0008, 4'h0, 32'h0,       32'h0000_8001, 1'b0);
    vecs[13] = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,         1, 32'h0,       4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0,        1'b1);
    vecs[14] = mk(1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 1, 32'h0,       4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0,        1'b1);
    vecs[15] = mk(1'b0, 3'b111, 32'h0000_0102, 32'h0,         1, 32'h0,       4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0,        1'b1);
    vecs[16] = mk(1'b1, 3'b010, 32'h0000_0000, 32'h0,         2, 32'h0,       4'hF, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0,        1'b0);
    vecs[17] = mk(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h3412_0000, 2, 32'hFFFF_FFFC, 4'hF, 32'h3412_0000, 32'h0,     4'h0, 32'h0,       32'h0,        1'b0);
    vecs[18] = mk(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         3, 32'hFFFF_FFFC, 4'h0, 32'h0,        32'h0000_0000, 4'h0, 32'h0,       32'h0000_3412, 1'b0);
    vecs[19] = mk(1'b1, 3'b000, 32'h0000_0101, 32'h1234_567F, 2, 32'h0000_0100, 4'h2, 32'h3456_7F00, 32'h0,     4'h0, 32'h0,       32'h0,        1'b0);
    vecs[20] = mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,         2, 32'h0000_0100, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0000_007F, 1'b0);
    vecs[21] = mk(1'b0, 3'b001, 32'h0000_0000, 32'h0,         2, 32'h0000_0000, 4'h0, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0000_0000, 1'b0);
    vecs[22] = mk(1'b1, 3'b010, 32'h0000_0100, 32'h0,         2, 32'h0000_0100, 4'hF, 32'h0,        32'h0,       4'h0, 32'h0,       32'h0,        1'b0);
    vecs[23] = mk(1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 2, 32'h0000_0104, 4'hF, 32'hCAFE_F00D, 32'h0,     4'h0, 32'h0,       32'h0,        1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      do_req(i, vecs[i]);
    end

    // Reset during SECOND of a crossing SW 0x102
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0102; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    chk("midrst_first_we", 32'(mem_we), 32'hC);
    @(posedge clk); #1;
    chk("midrst_second_we", 32'(mem_we), 32'h3);
    rst = 1'b1;
    #1;
    chk("midrst_we_drop", 32'(mem_we), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_hold_resp", 32'(resp_valid), 32'd0);
      chk("midrst_hold_we", 32'(mem_we), 32'd0);
      chk("midrst_hold_ready", 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_after_resp", 32'(resp_valid), 32'd0);
    chk("midrst_byte102", 32'(mem[10'h102]), 32'h44);
    chk("midrst_byte103", 32'(mem[10'h103]), 32'h33);
    $display("midrst: SW 0x102 interrupted in SECOND, mem_we dropped, no response");
    do_req(100, mk(1'b0, 3'b010, 32'h0000_0104, 32'h0, 2, 32'h0000_0104, 4'h0, 32'h0,
                   32'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0));
    do_req(101, mk(1'b0, 3'b010, 32'h0000_0100, 32'h0, 2, 32'h0000_0100, 4'h0, 32'h0,
                   32'h0, 4'h0, 32'h0, 32'h3344_0000, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
